// File: rtl/cpu0_mem_responder_if.sv
// CPU0 memory bus bundle: request side (en/rw/abus/wdata) from the master,
// completion side (rdata/ready/err) back from the responder.
interface cpu0_mem_responder_if;
  logic        en;
  logic        rw;
  logic [31:0] abus;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output en, rw, abus, wdata, input rdata, ready, err);
  modport slave  (input en, rw, abus, wdata, output rdata, ready, err);
endinterface

// File: rtl/cpu0_mem_responder.sv
// Clocked big-endian byte-addressed memory for the CPU0 bus with a fixed
// number of wait states between request sampling and the access.
module cpu0_mem_responder #(
  parameter int    DEPTH     = 128,
  parameter int    WAIT      = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                 clock,
  input  logic                 reset,
  cpu0_mem_responder_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         NO_WAIT  = (WAIT == 0);
  localparam logic [3:0] CNT_LOAD = 4'((WAIT == 0) ? 0 : WAIT - 1);
  localparam logic [31:0] LAST_OK = 32'(DEPTH - 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        rw_reg;
  logic        ready_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  logic [7:0]  mem [DEPTH];

  logic          access_now;
  logic          acc_rw;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;

  // With no wait states the access happens on the request edge itself,
  // so the live bus is used instead of the latched copy.
  always_comb begin
    access_now = 1'b0;
    acc_rw     = rw_reg;
    acc_addr   = addr_reg;
    acc_wdata  = wdata_reg;
    case (state_reg)
      S_IDLE: begin
        acc_rw     = bus.rw;
        acc_addr   = bus.abus;
        acc_wdata  = bus.wdata;
        access_now = bus.en && NO_WAIT;
      end
      S_WAIT:  access_now = (cnt_reg == 4'd0);
      default: access_now = 1'b0;
    endcase
  end

  assign acc_in_range = (acc_addr <= LAST_OK);
  assign idx          = acc_addr[AW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      assign rd_word[31-8*gi -: 8] = mem[idx + AW'(gi)];
    end
  endgenerate

  // Memory lives in the reset block only so a write can never land while
  // reset is asserted; reset itself leaves the array untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      rw_reg    <= 1'b0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
    end else if (access_now) begin
      state_reg <= S_RESP;
      ready_reg <= 1'b1;
      err_reg   <= !acc_in_range;
      if (!acc_in_range) begin
        rdata_reg <= 32'd0;
      end else if (acc_rw) begin
        rdata_reg <= rd_word;
      end else begin
        for (int b = 0; b < 4; b++) begin
          mem[idx + AW'(b)] <= acc_wdata[31-8*b -: 8];
        end
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.en) begin
            addr_reg  <= bus.abus;
            wdata_reg <= bus.wdata;
            rw_reg    <= bus.rw;
            cnt_reg   <= CNT_LOAD;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: cnt_reg <= cnt_reg - 4'd1;
        S_RESP: begin
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_reg;
  assign bus.ready = ready_reg;
  assign bus.err   = err_reg;

endmodule
